// File: rtl/matmul_host.sv
// Host-side job controller for one matmul engine: buffers A/B, streams them
// during the engine READ phase, captures out_c into C and exposes C via a read port.
package matmul_pkg;
  typedef struct packed {
    logic [15:0] rows;
    logic [15:0] cols;
  } matmul_dims_t;

  typedef enum logic [2:0] {IDLE, READ, CALCULATE, WRITE, ERROR} matmul_state_t;
endpackage

module matmul_host
  import matmul_pkg::*;
#(
  parameter int BUF_SIZE = 1024,
  parameter int TIMEOUT  = 65536,
  localparam int AW      = $clog2(BUF_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  matmul_dims_t  dims_a,
  input  matmul_dims_t  dims_b,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mm_start,
  output matmul_dims_t  mm_dims_a,
  output matmul_dims_t  mm_dims_b,
  output int            mm_in_a,
  output int            mm_in_b,
  input  matmul_state_t mm_state,
  input  int            mm_out_c
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_COLLECT} host_state_t;

  host_state_t state_reg, state_next;
  logic        done_next, err_next;

  logic [31:0] a_mem [BUF_SIZE];
  logic [31:0] b_mem [BUF_SIZE];
  logic [31:0] c_mem [BUF_SIZE];

  logic [31:0]   na_in, nb_in, nc_in;
  logic          shape_ok, go_ok;
  logic [AW-1:0] n_a_reg, n_c_reg;
  logic [AW-1:0] feed_cnt_reg, cap_cnt_reg;
  logic [AW-1:0] rd_ptr;
  logic          feed_issue, feed_valid_reg;
  logic [31:0]   a_rd_reg, b_rd_reg;
  logic          wr_d_reg, cap_en;
  logic [WW-1:0] wd_cnt_reg;
  logic          wd_fire;

  always_comb begin
    na_in = {16'b0, dims_a.rows} * {16'b0, dims_a.cols};
    nb_in = {16'b0, dims_b.rows} * {16'b0, dims_b.cols};
    nc_in = {16'b0, dims_a.rows} * {16'b0, dims_b.cols};
    shape_ok = (dims_a.rows != '0) && (dims_a.cols != '0) &&
               (dims_b.rows != '0) && (dims_b.cols != '0) &&
               (dims_a.cols == dims_b.rows) && (na_in == nb_in) &&
               (na_in < 32'(BUF_SIZE)) && (nc_in < 32'(BUF_SIZE));
  end

  assign go_ok   = (state_reg == S_IDLE) && go && (mm_state == IDLE);
  assign wd_fire = (wd_cnt_reg == WW'(TIMEOUT - 1));
  assign cap_en  = (state_reg == S_COLLECT) && wr_d_reg && (cap_cnt_reg < n_c_reg);

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (go_ok) begin
          if (shape_ok) state_next = S_START;
          else          err_next   = 1'b1;
        end
      end
      S_START: state_next = S_FEED;
      S_FEED: begin
        if (mm_state == ERROR) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else if (mm_state == CALCULATE) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mm_state == WRITE) state_next = S_COLLECT;
      end
      S_COLLECT: begin
        if ((cap_cnt_reg == n_c_reg) && (mm_state == IDLE)) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A regular transition this cycle wins over the watchdog.
    if ((state_reg != S_IDLE) && wd_fire && (state_next == state_reg)) begin
      state_next = S_IDLE;
      err_next   = 1'b1;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

  assign busy     = (state_reg != S_IDLE);
  assign mm_start = (state_reg == S_START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      wd_cnt_reg <= '0;
    end else if (state_reg != S_IDLE) begin
      wd_cnt_reg <= wd_cnt_reg + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_dims_a <= '0;
      mm_dims_b <= '0;
      n_a_reg   <= '0;
      n_c_reg   <= '0;
    end else if (go_ok && shape_ok) begin
      mm_dims_a <= dims_a;
      mm_dims_b <= dims_b;
      n_a_reg   <= na_in[AW-1:0];
      n_c_reg   <= nc_in[AW-1:0];
    end
  end

  // Operand k is read during the cycle before it is driven, so element 0 is
  // fetched in START and appears on the stream in the first FEED cycle.
  assign rd_ptr     = (state_reg == S_START) ? '0 : feed_cnt_reg;
  assign feed_issue = (state_next == S_FEED) &&
                      ((state_reg == S_START) ||
                       ((state_reg == S_FEED) && (feed_cnt_reg < n_a_reg)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feed_cnt_reg   <= '0;
      feed_valid_reg <= 1'b0;
    end else begin
      feed_valid_reg <= feed_issue;
      if (feed_issue) feed_cnt_reg <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    a_rd_reg <= a_mem[rd_ptr];
    b_rd_reg <= b_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (ld_en && !busy && !ld_sel) a_mem[ld_addr] <= ld_data;
    if (ld_en && !busy &&  ld_sel) b_mem[ld_addr] <= ld_data;
  end

  assign mm_in_a = feed_valid_reg ? a_rd_reg : '0;
  assign mm_in_b = feed_valid_reg ? b_rd_reg : '0;

  // out_c lags the engine WRITE state by one cycle, hence the delayed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_d_reg    <= 1'b0;
      cap_cnt_reg <= '0;
    end else begin
      wr_d_reg <= (mm_state == WRITE);
      if (state_reg != S_COLLECT) cap_cnt_reg <= '0;
      else if (cap_en)            cap_cnt_reg <= cap_cnt_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) c_mem[cap_cnt_reg] <= mm_out_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= c_mem[rd_addr];
  end

endmodule

// File: tb/tb_matmul_host.sv
// Directed bench for matmul_host with a small behavioural matmul engine that
// can answer normally, fault with ERROR, or freeze in READ.
module tb_matmul_host;
  import matmul_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  matmul_dims_t  dims_a = '0, dims_b = '0;
  logic          ld_en = 1'b0, ld_sel = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  logic          busy, done, err, mm_start;
  matmul_dims_t  mm_dims_a, mm_dims_b;
  int            mm_in_a, mm_in_b;
  matmul_state_t mm_state;
  int            mm_out_c;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matmul_host #(.BUF_SIZE(1024), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .dims_a(dims_a), .dims_b(dims_b),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .mm_start(mm_start), .mm_dims_a(mm_dims_a), .mm_dims_b(mm_dims_b),
    .mm_in_a(mm_in_a), .mm_in_b(mm_in_b), .mm_state(mm_state), .mm_out_c(mm_out_c)
  );

  // Behavioural engine: mode 0 normal, 1 answers start with ERROR, 2 freezes in READ.
  matmul_state_t eng_state = IDLE;
  int eng_mode = 0;
  bit eng_abort = 1'b0;
  int eng_cnt = 0, eng_ca = 0, eng_cb = 0, eng_na = 0, eng_nc = 0;
  int eng_a [16];
  int eng_b [16];
  int eng_out = 0;

  assign mm_state = eng_state;
  assign mm_out_c = eng_out;

  function automatic int dotp(int i, int j);
    int s = 0;
    for (int k = 0; k < eng_ca; k++) s += eng_a[i*eng_ca+k] * eng_b[k*eng_cb+j];
    return s;
  endfunction

  always @(posedge clk) begin
    if (eng_abort) eng_state <= IDLE;
    else case (eng_state)
      IDLE: if (mm_start) begin
        eng_ca    <= int'(mm_dims_a.cols);
        eng_cb    <= int'(mm_dims_b.cols);
        eng_na    <= int'(mm_dims_a.rows) * int'(mm_dims_a.cols);
        eng_nc    <= int'(mm_dims_a.rows) * int'(mm_dims_b.cols);
        eng_cnt   <= 0;
        eng_state <= (eng_mode == 1) ? ERROR : READ;
      end
      READ: if (eng_mode != 2) begin
        eng_a[eng_cnt] <= mm_in_a;
        eng_b[eng_cnt] <= mm_in_b;
        if (eng_cnt == eng_na - 1) begin eng_state <= CALCULATE; eng_cnt <= 0; end
        else eng_cnt <= eng_cnt + 1;
      end
      CALCULATE: begin
        if (eng_cnt == 2) begin eng_state <= WRITE; eng_cnt <= 0; end
        else eng_cnt <= eng_cnt + 1;
      end
      WRITE: begin
        eng_out <= dotp(eng_cnt / eng_cb, eng_cnt % eng_cb);
        if (eng_cnt == eng_nc - 1) eng_state <= IDLE;
        else eng_cnt <= eng_cnt + 1;
      end
      default: eng_state <= IDLE;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic matmul_dims_t mk(input int r, input int c);
    matmul_dims_t d;
    d.rows = 16'(r);
    d.cols = 16'(c);
    return d;
  endfunction

  task automatic ld(input bit sel, input int addr, input int data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = AW'(addr); ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int addr, input int exp);
    rd_addr = AW'(addr);
    tick();
    check(tag, rd_data, exp);
  endtask

  // Cycle n counts from the go sampling edge: n=1 is T+1.
  task automatic run_job(input matmul_dims_t da, input matmul_dims_t db, input bit inject,
                         output int n_start, output int n_done, output int n_err,
                         output int err_at, output int caps, output int a_t2,
                         output int b_t2, output int start_at);
    int ended = 0;
    n_start = 0; n_done = 0; n_err = 0; err_at = -1; caps = 0;
    a_t2 = 0; b_t2 = 0; start_at = -1;
    dims_a = da; dims_b = db; go = 1'b1;
    tick();
    go = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (mm_start) begin n_start++; start_at = n; end
      if (n == 2) begin a_t2 = mm_in_a; b_t2 = mm_in_b; end
      if (busy) caps = int'(dut.cap_cnt_reg);
      if (done) n_done++;
      if (err) begin n_err++; err_at = n; end
      ld_en = 1'b0;
      if (inject && n == 2) begin ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3; ld_data = 99; end
      if (inject && n == 3) begin ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 3; ld_data = 77; end
      if (done || err) begin ended = 1; break; end
      tick();
    end
    ld_en = 1'b0;
    repeat (3) begin
      tick();
      if (mm_start) n_start++;
      if (done) n_done++;
      if (err) n_err++;
    end
    check("job_ends", ended, 1);
  endtask

  int ns, nd, ne, ea, cp, a2, b2, sa;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state, sampled while reset is held.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_dims_a", int'(mm_dims_a), 0);
    check("rst_in_a", mm_in_a, 0);
    rst = 1'b0;
    tick();

    // 2x2 job with writes attempted while busy.
    for (int i = 0; i < 4; i++) ld(1'b0, i, i + 1);
    for (int i = 0; i < 4; i++) ld(1'b1, i, i + 5);
    run_job(mk(2, 2), mk(2, 2), 1'b1, ns, nd, ne, ea, cp, a2, b2, sa);
    check("j1_start_pulses", ns, 1);
    check("j1_start_at", sa, 1);
    check("j1_a0_at_t2", a2, 1);
    check("j1_b0_at_t2", b2, 5);
    check("j1_done", nd, 1);
    check("j1_err", ne, 0);
    check("j1_busy_after", busy, 0);
    check("j1_caps", cp, 4);
    rd_check("j1_c0", 0, 19);
    rd_check("j1_c1", 1, 22);
    rd_check("j1_c2", 2, 43);
    rd_check("j1_c3", 3, 50);

    // Write after done is stored and seen by the very next job.
    ld(1'b0, 0, 2);
    run_job(mk(2, 2), mk(2, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("j2_done", nd, 1);
    rd_check("j2_c0", 0, 24);
    rd_check("j2_c1", 1, 28);
    rd_check("j2_c3", 3, 50);

    // 2x3 by 3x2.
    for (int i = 0; i < 6; i++) ld(1'b0, i, i + 1);
    for (int i = 0; i < 6; i++) ld(1'b1, i, i + 7);
    run_job(mk(2, 3), mk(3, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("j3_done", nd, 1);
    check("j3_caps", cp, 4);
    rd_check("j3_c0", 0, 58);
    rd_check("j3_c1", 1, 64);
    rd_check("j3_c2", 2, 139);
    rd_check("j3_c3", 3, 154);

    // Shape rejects.
    run_job(mk(2, 3), mk(2, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("rej1_err_at", ea, 1);
    check("rej1_err_pulses", ne, 1);
    check("rej1_start", ns, 0);
    run_job(mk(1, 2), mk(2, 3), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("rej2_err_at", ea, 1);
    check("rej2_start", ns, 0);
    run_job(mk(0, 2), mk(2, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("rej3_err_at", ea, 1);
    check("rej3_start", ns, 0);
    check("rej3_done", nd, 0);

    // Engine answers start with ERROR.
    eng_mode = 1;
    run_job(mk(2, 3), mk(3, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    eng_mode = 0;
    check("eerr_err_at", ea, 3);
    check("eerr_err_pulses", ne, 1);
    check("eerr_done", nd, 0);
    check("eerr_busy", busy, 0);
    rd_check("eerr_c0", 0, 58);
    rd_check("eerr_c3", 3, 154);

    // Engine frozen in READ: watchdog fires 16 cycles after FEED entry (T+2).
    eng_mode = 2;
    run_job(mk(2, 3), mk(3, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("wdog_err_at", ea, 18);
    check("wdog_err_pulses", ne, 1);
    check("wdog_busy", busy, 0);
    eng_abort = 1'b1;
    tick();
    eng_abort = 1'b0;
    eng_mode = 0;
    tick();

    // Reset mid-COLLECT, go while the engine is still writing, then a full job.
    for (int i = 0; i < 4; i++) ld(1'b0, i, i + 1);
    ld(1'b1, 0, 2); ld(1'b1, 1, 0); ld(1'b1, 2, 1); ld(1'b1, 3, 3);
    dims_a = mk(2, 2); dims_b = mk(2, 2); go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 60 && int'(dut.cap_cnt_reg) != 2; k++) tick();
    check("mid_caps_reached", int'(dut.cap_cnt_reg), 2);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dims_a", int'(mm_dims_a), 0);
    check("mid_rst_rd_data", rd_data, 0);
    #1;
    rst = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("mid_go_ignored_start", mm_start, 0);
    check("mid_go_ignored_busy", busy, 0);
    tick();
    run_job(mk(2, 2), mk(2, 2), 1'b0, ns, nd, ne, ea, cp, a2, b2, sa);
    check("j4_done", nd, 1);
    rd_check("j4_c0", 0, 4);
    rd_check("j4_c1", 1, 6);
    rd_check("j4_c2", 2, 10);
    rd_check("j4_c3", 3, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
